// File: rtl/pov_led_shifter_if.sv
// Avalon-MM slave bus bundle for pov_led_shifter: word address, select, write strobe and data.
// The CPU side uses the master modport and the shifter uses the slave modport.
interface pov_led_shifter_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input readdata);
    modport slave  (input address, input chipselect, input write_n, input writedata,
                    output readdata);
endinterface

// File: rtl/pov_led_shifter.sv
// FIFO-buffered column words shifted MSB-first onto a serial LED driver chain, then latched.
// Optional interrupt on drain is compiled in with POV_SHIFT_IRQ_EN.
module pov_led_shifter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 4,
    parameter int LATCH_CYC  = 2
) (
    input  logic               clk,
    input  logic               reset,
    pov_led_shifter_if.slave   bus,
    input  logic               led_enable,
    output logic               led_sclk,
    output logic               led_sdat,
`ifdef POV_SHIFT_IRQ_EN
    output logic               irq,
`endif
    output logic               led_latch
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BC_W  = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_LATCH} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level;
    logic                ovf;
    logic [15:0]         div;
    logic [15:0]         div_lat;
    logic [15:0]         cyc_cnt;
    logic [BC_W-1:0]     bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   head;

    logic wr, push, pop, push_ok, full, empty, busy;
    logic [15:0] div_eff;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign push    = wr && (bus.address == 2'd0);
    assign pop     = (state == S_LOAD);
    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign busy    = (state != S_IDLE);
    assign push_ok = push && (!full || pop);
    assign div_eff = (div == 16'd0) ? 16'd1 : div;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.writedata[DATA_W-1:0];
    end

    // A push into a full FIFO still lands when the shifter pops in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            div    <= 16'(DIV_RESET);
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                level <= level + 1'b1;
            else if (!push_ok && pop)
                level <= level - 1'b1;
            if (wr && bus.address == 2'd1)
                ovf <= 1'b0;
            else if (push && !push_ok)
                ovf <= 1'b1;
            if (wr && bus.address == 2'd2)
                div <= bus.writedata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            div_lat   <= 16'd1;
            led_sclk  <= 1'b0;
            led_sdat  <= 1'b0;
            led_latch <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (led_enable && !empty)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    shreg    <= head;
                    bit_cnt  <= BC_W'(DATA_W);
                    div_lat  <= div_eff;
                    cyc_cnt  <= div_eff - 16'd1;
                    led_sclk <= 1'b0;
                    led_sdat <= head[DATA_W-1];
                    state    <= S_LOW;
                end
                S_LOW: begin
                    if (cyc_cnt == 16'd0) begin
                        led_sclk <= 1'b1;
                        cyc_cnt  <= div_lat - 16'd1;
                        state    <= S_HIGH;
                    end else begin
                        cyc_cnt <= cyc_cnt - 16'd1;
                    end
                end
                S_HIGH: begin
                    if (cyc_cnt == 16'd0) begin
                        shreg    <= shreg << 1;
                        bit_cnt  <= bit_cnt - 1'b1;
                        led_sclk <= 1'b0;
                        if (bit_cnt == BC_W'(1)) begin
                            led_sdat  <= 1'b0;
                            led_latch <= 1'b1;
                            cyc_cnt   <= 16'(LATCH_CYC - 1);
                            state     <= S_LATCH;
                        end else begin
                            led_sdat <= shreg[DATA_W-2];
                            cyc_cnt  <= div_lat - 16'd1;
                            state    <= S_LOW;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt - 16'd1;
                    end
                end
                S_LATCH: begin
                    if (cyc_cnt == 16'd0) begin
                        led_latch <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef POV_SHIFT_IRQ_EN
    logic irq_mask, irq_pend;

    // Pending is raised only when the last queued word has fully latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= 1'b0;
            irq_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr && bus.address == 2'd3)
                irq_mask <= bus.writedata[0];
            if (state == S_LATCH && cyc_cnt == 16'd0 && empty)
                irq_pend <= 1'b1;
            else if (wr && bus.address == 2'd3 && bus.writedata[1])
                irq_pend <= 1'b0;
            irq <= irq_pend & irq_mask;
        end
    end
`endif

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd1: begin
                bus.readdata[31]         = ovf;
                bus.readdata[30]         = busy;
                bus.readdata[29]         = full;
                bus.readdata[28]         = empty;
                bus.readdata[LVL_W-1:0]  = level;
            end
            2'd2: bus.readdata[15:0] = div;
`ifdef POV_SHIFT_IRQ_EN
            2'd3: bus.readdata[1:0] = {irq_pend, irq_mask};
`endif
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pov_led_shifter.sv
// Directed bench for pov_led_shifter: shifting, FIFO limits, enable gating, reset and
// (with POV_SHIFT_IRQ_EN) the drain interrupt.
module tb_pov_led_shifter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic led_enable = 1'b0;
    logic led_sclk, led_sdat, led_latch;
`ifdef POV_SHIFT_IRQ_EN
    logic irq;
`endif

    int checks = 0;
    int errors = 0;

    pov_led_shifter_if bus();

    pov_led_shifter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .led_enable (led_enable),
        .led_sclk   (led_sclk),
        .led_sdat   (led_sdat),
`ifdef POV_SHIFT_IRQ_EN
        .irq        (irq),
`endif
        .led_latch  (led_latch)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.readdata;
    endtask

    // Watches the serial pins once per cycle and rebuilds the word from sdat at each rising sclk.
    task automatic captureWord(input int stopAt, input int dropAt, input int expHalf,
                               output logic [31:0] word, output int pulses,
                               output int badWidth, output int latchLen, output int timedOut);
        logic prevSclk;
        int hiRun, loRun;
        bit seenLatch, done;
        prevSclk = 1'b0; hiRun = 0; loRun = 0; seenLatch = 0; done = 0;
        word = '0; pulses = 0; badWidth = 0; latchLen = 0; timedOut = 1;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (led_sclk && !prevSclk) begin
                if (pulses > 0 && loRun != expHalf) badWidth++;
                pulses++;
                word = {word[30:0], led_sdat};
                hiRun = 0;
                if (pulses == dropAt) led_enable = 1'b0;
                if (pulses == stopAt) begin done = 1; timedOut = 0; end
            end
            if (!led_sclk && prevSclk) begin
                if (hiRun != expHalf) badWidth++;
                loRun = 0;
            end
            if (led_sclk) hiRun++; else loRun++;
            if (led_latch) begin
                seenLatch = 1;
                latchLen++;
                if (led_sclk) badWidth++;
            end else if (seenLatch) begin
                done = 1;
                timedOut = 0;
            end
            prevSclk = led_sclk;
        end
    endtask

    initial begin
        logic [31:0] rd, word;
        int pulses, badWidth, latchLen, timedOut;

        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst sclk", 32'(led_sclk), 32'd0);
        checkOutput("rst sdat", 32'(led_sdat), 32'd0);
        checkOutput("rst latch", 32'(led_latch), 32'd0);
        readReg(2'd1, rd); checkOutput("rst status", rd, 32'h1000_0000);
        readReg(2'd2, rd); checkOutput("rst div", rd, 32'd4);
        readReg(2'd0, rd); checkOutput("addr0 read", rd, 32'd0);

        $display("[TB] single word, div=2");
        applyStimulus(2'd2, 32'd2);
        readReg(2'd2, rd); checkOutput("div write", rd, 32'd2);
        led_enable = 1'b1;
        applyStimulus(2'd0, 32'h8000_0001);
        captureWord(0, 0, 2, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t1 timeout", 32'(timedOut), 32'd0);
        checkOutput("t1 pulses", 32'(pulses), 32'd32);
        checkOutput("t1 word", word, 32'h8000_0001);
        checkOutput("t1 widths", 32'(badWidth), 32'd0);
        checkOutput("t1 latch len", 32'(latchLen), 32'd2);
        readReg(2'd1, rd); checkOutput("t1 status", rd, 32'h1000_0000);

        $display("[TB] overflow with enable low");
        led_enable = 1'b0;
        for (int i = 0; i < 17; i++) applyStimulus(2'd0, 32'h100 + 32'(i));
        readReg(2'd1, rd); checkOutput("t2 full ovf", rd, 32'hA000_0010);
        checkOutput("t2 sclk idle", 32'(led_sclk), 32'd0);
        applyStimulus(2'd1, 32'd0);
        readReg(2'd1, rd); checkOutput("t2 ovf clear", rd, 32'h2000_0010);

        // Push lands in the LOAD cycle, so pop and push coincide while full.
        @(negedge clk);
        led_enable = 1'b1;
        applyStimulus(2'd0, 32'hCAFE_0001);
        readReg(2'd1, rd); checkOutput("t2 push+pop full", rd, 32'h6000_0010);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        led_enable = 1'b0;
        readReg(2'd1, rd); checkOutput("t2 flush status", rd, 32'h1000_0000);

        $display("[TB] three words in order, div=0 acts as 1");
        applyStimulus(2'd2, 32'd0);
        applyStimulus(2'd0, 32'hA5A5_0F0F);
        applyStimulus(2'd0, 32'h1234_5678);
        applyStimulus(2'd0, 32'hFFFF_0000);
        led_enable = 1'b1;
        captureWord(0, 0, 1, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t3 w0 timeout", 32'(timedOut), 32'd0);
        checkOutput("t3 w0", word, 32'hA5A5_0F0F);
        checkOutput("t3 w0 widths", 32'(badWidth), 32'd0);
        readReg(2'd1, rd); checkOutput("t3 idle gap", rd, 32'h0000_0002);
        @(negedge clk);
        readReg(2'd1, rd); checkOutput("t3 load after gap", rd, 32'h4000_0002);
        captureWord(0, 0, 1, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t3 w1", word, 32'h1234_5678);
        captureWord(0, 0, 1, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t3 w2", word, 32'hFFFF_0000);
        checkOutput("t3 w2 latch len", 32'(latchLen), 32'd2);
        readReg(2'd1, rd); checkOutput("t3 final status", rd, 32'h1000_0000);

        $display("[TB] enable dropped mid-word");
        led_enable = 1'b0;
        applyStimulus(2'd2, 32'd1);
        applyStimulus(2'd0, 32'hDEAD_BEEF);
        applyStimulus(2'd0, 32'h0F0F_0F0F);
        led_enable = 1'b1;
        captureWord(0, 10, 1, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t4 w0 timeout", 32'(timedOut), 32'd0);
        checkOutput("t4 w0", word, 32'hDEAD_BEEF);
        checkOutput("t4 w0 latch len", 32'(latchLen), 32'd2);
        repeat (10) @(negedge clk);
        checkOutput("t4 held sclk", 32'(led_sclk), 32'd0);
        readReg(2'd1, rd); checkOutput("t4 held status", rd, 32'h0000_0001);
        led_enable = 1'b1;
        captureWord(0, 0, 1, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t4 w1", word, 32'h0F0F_0F0F);

        $display("[TB] reset mid-word");
        led_enable = 1'b0;
        applyStimulus(2'd0, 32'hFFFF_FFFF);
        applyStimulus(2'd0, 32'h1234_5678);
        led_enable = 1'b1;
        captureWord(5, 0, 1, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t5 reach bit5", 32'(timedOut), 32'd0);
        checkOutput("t5 sdat before", 32'(led_sdat), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t5 sclk", 32'(led_sclk), 32'd0);
        checkOutput("t5 sdat", 32'(led_sdat), 32'd0);
        checkOutput("t5 latch", 32'(led_latch), 32'd0);
        readReg(2'd1, rd); checkOutput("t5 status", rd, 32'h1000_0000);
        readReg(2'd2, rd); checkOutput("t5 div", rd, 32'd4);

`ifdef POV_SHIFT_IRQ_EN
        $display("[TB] drain interrupt");
        applyStimulus(2'd3, 32'd1);
        readReg(2'd3, rd); checkOutput("t6 mask", rd, 32'd1);
        checkOutput("t6 irq idle", 32'(irq), 32'd0);
        applyStimulus(2'd0, 32'h0000_00FF);
        captureWord(0, 0, 4, word, pulses, badWidth, latchLen, timedOut);
        checkOutput("t6 word", word, 32'h0000_00FF);
        @(negedge clk);
        checkOutput("t6 irq set", 32'(irq), 32'd1);
        readReg(2'd3, rd); checkOutput("t6 pend", rd, 32'd3);
        applyStimulus(2'd3, 32'd2);
        @(negedge clk);
        checkOutput("t6 irq clear", 32'(irq), 32'd0);
        readReg(2'd3, rd); checkOutput("t6 reg clear", rd, 32'd0);
`else
        $display("[TB] addr3 without irq");
        applyStimulus(2'd3, 32'd3);
        readReg(2'd3, rd); checkOutput("addr3 ignored", rd, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
